// File: rtl/key_buf_pkg.sv
// key_buf_pkg
// Shared types and constants for the keypad entry buffer.
//   key_state_t   : entry FSM states (EMPTY, FILL, FULL)
//   DEF_*_CODE    : default in-band control codes (clear, backspace, enter)
//   cnt_width()   : width of a 0..depth digit counter
package key_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } key_state_t;

  localparam logic [3:0] DEF_CLR_CODE = 4'hF;
  localparam logic [3:0] DEF_BS_CODE  = 4'hE;
  localparam logic [3:0] DEF_ENT_CODE = 4'hD;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// key_shift_reg
// DEPTH x CODE_W left-shifting digit register with a valid-digit count.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : empty the register (highest priority)
//   push       : append din at the LSB end
//   pop        : drop the newest digit (zero fill at the top)
//   sat_mode   : push while full -> 0: discard oldest, 1: drop din
//   din        : digit to append
//   data       : stored digits, newest in LSBs
//   cnt        : number of valid digits
//   full       : cnt == DEPTH
module key_shift_reg
  import key_buf_pkg::*;
#(
  parameter int unsigned CODE_W = 4,
  parameter int unsigned DEPTH  = 6,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      sat_mode,
  input  logic [CODE_W-1:0]         din,
  output logic [DEPTH*CODE_W-1:0]   data,
  output logic [CNT_W-1:0]          cnt,
  output logic                      full
);

  assign full = (cnt == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      cnt  <= '0;
    end else if (clear) begin
      data <= '0;
      cnt  <= '0;
    end else if (push) begin
      if (!full) begin
        data <= {data[(DEPTH-1)*CODE_W-1:0], din};
        cnt  <= cnt + CNT_W'(1);
      end else if (!sat_mode) begin
        // Full and discarding: the oldest digit falls off the top, count holds.
        data <= {data[(DEPTH-1)*CODE_W-1:0], din};
      end
    end else if (pop && (cnt != '0)) begin
      data <= {{CODE_W{1'b0}}, data[DEPTH*CODE_W-1:CODE_W]};
      cnt  <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_code_buffer.sv
// key_code_buffer
// Keypad entry buffer: keeps the last DEPTH digits, decodes in-band
// clear / backspace / enter codes and snapshots the entry on enter.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   press         : one-cycle key strobe
//   scan_code     : key code, valid with press
//   buf_code      : live entry, newest digit in LSBs
//   buf_flag      : thermometer of valid digits, bit0 = newest
//   buf_cnt       : valid digit count
//   full          : buf_cnt == DEPTH
//   overflow      : one-cycle pulse, digit pressed while full
//   commit_code   : entry snapshot taken at enter
//   commit_cnt    : digit count of the snapshot
//   commit_valid  : one-cycle pulse on commit
// Optional (KEY_BUF_ODD_FILTER_EN):
//   odd_code, odd_cnt : second buffer holding only odd digits
module key_code_buffer
  import key_buf_pkg::*;
#(
  parameter int unsigned        CODE_W   = 4,
  parameter int unsigned        DEPTH    = 6,
  parameter logic [CODE_W-1:0]  CLR_CODE = CODE_W'(DEF_CLR_CODE),
  parameter logic [CODE_W-1:0]  BS_CODE  = CODE_W'(DEF_BS_CODE),
  parameter logic [CODE_W-1:0]  ENT_CODE = CODE_W'(DEF_ENT_CODE),
  parameter bit                 SAT_MODE = 1'b0,
  localparam int unsigned       CNT_W    = cnt_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      press,
  input  logic [CODE_W-1:0]         scan_code,
  output logic [DEPTH*CODE_W-1:0]   buf_code,
  output logic [DEPTH-1:0]          buf_flag,
  output logic [CNT_W-1:0]          buf_cnt,
  output logic                      full,
  output logic                      overflow,
  output logic [DEPTH*CODE_W-1:0]   commit_code,
  output logic [CNT_W-1:0]          commit_cnt,
  output logic                      commit_valid
`ifdef KEY_BUF_ODD_FILTER_EN
  ,
  output logic [DEPTH*CODE_W-1:0]   odd_code,
  output logic [CNT_W-1:0]          odd_cnt
`endif
);

  key_state_t state, state_nxt;

  logic is_clr, is_bs, is_ent, is_dig;
  logic bs_ok, ent_ok;
  logic live_clear;

  always_comb begin
    is_clr = press && (scan_code == CLR_CODE);
    is_bs  = press && (scan_code == BS_CODE);
    is_ent = press && (scan_code == ENT_CODE);
    is_dig = press && !(scan_code == CLR_CODE || scan_code == BS_CODE ||
                        scan_code == ENT_CODE);
    // The FSM state tracks emptiness, so BS/ENT on an empty buffer are no-ops.
    bs_ok      = is_bs  && (state != EMPTY);
    ent_ok     = is_ent && (state != EMPTY);
    live_clear = is_clr || ent_ok;
  end

  key_shift_reg #(
    .CODE_W (CODE_W),
    .DEPTH  (DEPTH)
  ) u_live (
    .clk      (clk),
    .rst      (rst),
    .clear    (live_clear),
    .push     (is_dig),
    .pop      (bs_ok),
    .sat_mode (SAT_MODE),
    .din      (scan_code),
    .data     (buf_code),
    .cnt      (buf_cnt),
    .full     (full)
  );

`ifdef KEY_BUF_ODD_FILTER_EN
  logic odd_full;
  logic odd_push, odd_pop;

  always_comb begin
    odd_push = is_dig && scan_code[0];
    // Pop only when the digit leaving the live buffer was itself odd.
    odd_pop  = bs_ok && buf_code[0];
  end

  key_shift_reg #(
    .CODE_W (CODE_W),
    .DEPTH  (DEPTH)
  ) u_odd (
    .clk      (clk),
    .rst      (rst),
    .clear    (live_clear),
    .push     (odd_push),
    .pop      (odd_pop),
    .sat_mode (SAT_MODE),
    .din      (scan_code),
    .data     (odd_code),
    .cnt      (odd_cnt),
    .full     (odd_full)
  );
`endif

  always_comb begin
    buf_flag = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      buf_flag[i] = (CNT_W'(i) < buf_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (is_dig) state_nxt = FILL;
      end
      FILL: begin
        if (is_clr || is_ent)                               state_nxt = EMPTY;
        else if (is_bs && buf_cnt == CNT_W'(1))             state_nxt = EMPTY;
        else if (is_dig && buf_cnt == CNT_W'(DEPTH - 1))    state_nxt = FULL;
      end
      FULL: begin
        if (is_clr || is_ent) state_nxt = EMPTY;
        else if (is_bs)       state_nxt = FILL;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow     <= 1'b0;
      commit_code  <= '0;
      commit_cnt   <= '0;
      commit_valid <= 1'b0;
    end else begin
      overflow     <= is_dig && full;
      commit_valid <= ent_ok;
      if (ent_ok) begin
        commit_code <= buf_code;
        commit_cnt  <= buf_cnt;
      end
    end
  end

endmodule

// File: tb/tb_key_code_buffer.sv
module tb_key_code_buffer;

  localparam int D = 6;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic press = 1'b0;
  logic [3:0] scan_code = 4'h0;

  logic [23:0] buf_code [2];
  logic [5:0]  buf_flag [2];
  logic [2:0]  buf_cnt  [2];
  logic        full     [2];
  logic        overflow [2];
  logic [23:0] commit_code [2];
  logic [2:0]  commit_cnt  [2];
  logic        commit_valid [2];

  always #5 clk = ~clk;

  key_code_buffer #(.CODE_W(4), .DEPTH(6), .SAT_MODE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .press(press), .scan_code(scan_code),
    .buf_code(buf_code[0]), .buf_flag(buf_flag[0]), .buf_cnt(buf_cnt[0]),
    .full(full[0]), .overflow(overflow[0]), .commit_code(commit_code[0]),
    .commit_cnt(commit_cnt[0]), .commit_valid(commit_valid[0])
  );

  key_code_buffer #(.CODE_W(4), .DEPTH(6), .SAT_MODE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .press(press), .scan_code(scan_code),
    .buf_code(buf_code[1]), .buf_flag(buf_flag[1]), .buf_cnt(buf_cnt[1]),
    .full(full[1]), .overflow(overflow[1]), .commit_code(commit_code[1]),
    .commit_cnt(commit_cnt[1]), .commit_valid(commit_valid[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: digits kept oldest-first in a plain array.
  int dig [2][D];
  int cnt [2];
  int cm_code [2];
  int cm_cnt [2];
  bit cm_v [2];
  bit ovf [2];

  function automatic int pack(input int m);
    int code = 0;
    for (int i = 0; i < cnt[m]; i++) code = code * 16 + dig[m][i];
    return code;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        cnt[m] = 0; cm_code[m] = 0; cm_cnt[m] = 0; cm_v[m] = 0; ovf[m] = 0;
        for (int i = 0; i < D; i++) dig[m][i] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        ovf[m] = 0;
        cm_v[m] = 0;
        if (press) begin
          if (scan_code == 4'hF) cnt[m] = 0;
          else if (scan_code == 4'hE) begin
            if (cnt[m] > 0) cnt[m]--;
          end else if (scan_code == 4'hD) begin
            if (cnt[m] > 0) begin
              cm_code[m] = pack(m); cm_cnt[m] = cnt[m]; cm_v[m] = 1; cnt[m] = 0;
            end
          end else if (cnt[m] < D) begin
            dig[m][cnt[m]] = int'(scan_code);
            cnt[m]++;
          end else begin
            ovf[m] = 1;
            if (m == 0) begin
              for (int i = 0; i < D - 1; i++) dig[m][i] = dig[m][i+1];
              dig[m][D-1] = int'(scan_code);
            end
          end
        end
      end
    end
  end

  // Single compare process against the model, every cycle.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d buf_code", m), 32'(buf_code[m]), 32'(pack(m)));
      chk($sformatf("m%0d buf_cnt", m), 32'(buf_cnt[m]), 32'(cnt[m]));
      chk($sformatf("m%0d buf_flag", m), 32'(buf_flag[m]), 32'((1 << cnt[m]) - 1));
      chk($sformatf("m%0d full", m), 32'(full[m]), 32'(cnt[m] == D));
      chk($sformatf("m%0d overflow", m), 32'(overflow[m]), 32'(ovf[m]));
      chk($sformatf("m%0d commit_code", m), 32'(commit_code[m]), 32'(cm_code[m]));
      chk($sformatf("m%0d commit_cnt", m), 32'(commit_cnt[m]), 32'(cm_cnt[m]));
      chk($sformatf("m%0d commit_valid", m), 32'(commit_valid[m]), 32'(cm_v[m]));
    end
  end

  task automatic key(input logic [3:0] c);
    press = 1'b1;
    scan_code = c;
    @(negedge clk);
    press = 1'b0;
  endtask

  initial begin
    logic [3:0] seq [7];
    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};

    repeat (2) @(negedge clk);
    chk("reset buf_code", 32'(buf_code[0]), 32'h0);
    chk("reset commit_valid", 32'(commit_valid[0]), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // 1,2,3
    for (int i = 0; i < 3; i++) key(seq[i]);
    chk("p123 buf_code", 32'(buf_code[0]), 32'h000123);
    chk("p123 buf_cnt", 32'(buf_cnt[0]), 32'd3);
    chk("p123 buf_flag", 32'(buf_flag[0]), 32'b000111);
    // 4..7
    for (int i = 3; i < 7; i++) begin
      key(seq[i]);
      if (i == 6) begin
        chk("ovf7 m0", 32'(overflow[0]), 32'h1);
        chk("ovf7 m1", 32'(overflow[1]), 32'h1);
      end else begin
        chk("ovf pre7", 32'(overflow[0]), 32'h0);
      end
    end
    chk("p1to7 m0 code", 32'(buf_code[0]), 32'h234567);
    chk("p1to7 m1 code", 32'(buf_code[1]), 32'h123456);
    chk("p1to7 full", 32'(full[0]), 32'h1);
    @(negedge clk);
    chk("ovf cleared", 32'(overflow[0]), 32'h0);

    // clear, then 1,2,3,BS,ENT
    key(4'hF);
    chk("clr cnt", 32'(buf_cnt[0]), 32'h0);
    key(4'h1); key(4'h2); key(4'h3); key(4'hE);
    chk("bs buf_code", 32'(buf_code[0]), 32'h000012);
    key(4'hD);
    chk("ent commit_code", 32'(commit_code[0]), 32'h000012);
    chk("ent commit_cnt", 32'(commit_cnt[0]), 32'd2);
    chk("ent commit_valid", 32'(commit_valid[0]), 32'h1);
    chk("ent live clear", 32'(buf_code[0]), 32'h0);
    key(4'hD);
    chk("ent empty no pulse", 32'(commit_valid[0]), 32'h0);
    chk("ent empty keeps commit", 32'(commit_code[0]), 32'h000012);
    key(4'hE);
    chk("bs empty cnt", 32'(buf_cnt[0]), 32'h0);

    // Randomized presses, biased toward digits so the buffer fills often.
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if ($urandom_range(0, 2) != 0) begin
        press = 1'b1;
        if (r < 13)       scan_code = 4'($urandom_range(0, 12));
        else if (r < 15)  scan_code = 4'hE;
        else if (r < 17)  scan_code = 4'hD;
        else if (r < 18)  scan_code = 4'hF;
        else              scan_code = 4'($urandom_range(0, 15));
      end else begin
        press = 1'b0;
        scan_code = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
    end
    press = 1'b0;

    // Asynchronous reset mid-entry.
    key(4'h5); key(4'h6); key(4'hD); key(4'h7);
    #3 rst = 1'b0;
    #1;
    chk("async buf_code", 32'(buf_code[0]), 32'h0);
    chk("async buf_cnt", 32'(buf_cnt[0]), 32'h0);
    chk("async commit_code", 32'(commit_code[0]), 32'h0);
    chk("async commit_cnt", 32'(commit_cnt[0]), 32'h0);
    chk("async buf_flag", 32'(buf_flag[1]), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    key(4'h9);
    chk("post reset digit", 32'(buf_code[0]), 32'h000009);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
